// File: rtl/mspu_pkg.sv
// Shared widths and converter state encoding for the mspu packet converters.
// Used by both the 512->32 ingress and the 32->512 egress converters.
package mspu_pkg;

    localparam int WORD_W      = 32;
    localparam int BEAT_W      = 512;
    localparam int BEAT_WORDS  = 16;
    localparam int IFMEM_BYTES = 2048;

    typedef enum logic [1:0] {IDLE, READ, OUT} conv_state_t;

    // Byte address of a data-memory word; wraps silently in 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] wordIdx);
        return base + (wordIdx << 2);
    endfunction

endpackage

// File: rtl/datawidthconv_32_to_512_if.sv
// Control, data-memory read port and 512-bit packet source signals of the egress converter.
// The converter takes the master side; memory, packet sink and controller take the slave side.
interface datawidthconv_32_to_512_if;
    import mspu_pkg::*;

    logic                kick;
    logic                busy;
    logic                done;
    logic [WORD_W-1:0]   data_addr;
    logic                data_oe;
    logic [WORD_W-1:0]   data_dout;
    logic                src_sop;
    logic                src_eop;
    logic                src_valid;
    logic [BEAT_W-1:0]   src_dout;
    logic                src_ready;

    modport master (
        input  kick,
        output busy,
        output done,
        output data_addr,
        output data_oe,
        input  data_dout,
        output src_sop,
        output src_eop,
        output src_valid,
        output src_dout,
        input  src_ready
    );

    modport slave (
        output kick,
        input  busy,
        input  done,
        input  data_addr,
        input  data_oe,
        output data_dout,
        input  src_sop,
        input  src_eop,
        input  src_valid,
        input  src_dout,
        output src_ready
    );

endinterface

// File: rtl/datawidthconv_32_to_512.sv
// Egress converter: reads NUM_BEATS*16 words from the 32-bit data memory and streams them
// out as 512-bit beats with sop/eop/valid and ready backpressure.
module datawidthconv_32_to_512
    import mspu_pkg::*;
#(
    parameter int          NUM_BEATS = 32,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic clk,
    input  logic reset,
    datawidthconv_32_to_512_if.master bus
);

    localparam int BCNT_W = $clog2(NUM_BEATS) + 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NUM_BEATS - 1);

    conv_state_t         state_q, state_d;
    logic [BCNT_W-1:0]   beat_q, beat_d;
    logic [3:0]          word_q, word_d;
    logic [3:0]          cap_q, cap_d;
    logic                oe_q, oe_d;
    logic                pend_q, pend_d;
    logic [31:0]         addr_q, addr_d;
    logic [BEAT_W-1:0]   beatBuf_q, beatBuf_d;
    logic                done_q, done_d;
    logic                lastBeat;

    assign lastBeat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            word_q    <= '0;
            cap_q     <= '0;
            oe_q      <= 1'b0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            beatBuf_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            cap_q     <= cap_d;
            oe_q      <= oe_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            beatBuf_q <= beatBuf_d;
            done_q    <= done_d;
        end
    end

    // pend_q marks the cycle in which the word requested a cycle earlier is on data_dout.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        word_d    = word_q;
        cap_d     = cap_q;
        oe_d      = oe_q;
        pend_d    = oe_q;
        addr_d    = addr_q;
        beatBuf_d = beatBuf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.kick) begin
                    state_d = READ;
                    beat_d  = '0;
                    word_d  = '0;
                    cap_d   = '0;
                    oe_d    = 1'b1;
                    addr_d  = word_addr(ADDR_BASE, 32'd0);
                end
            end
            READ: begin
                if (oe_q) begin
                    if (word_q == 4'd15) begin
                        oe_d = 1'b0;
                    end else begin
                        word_d = word_q + 4'd1;
                        addr_d = word_addr(ADDR_BASE, (32'(beat_q) << 4) | 32'(word_q + 4'd1));
                    end
                end
                if (pend_q) begin
                    beatBuf_d = {bus.data_dout, beatBuf_q[BEAT_W-1:WORD_W]};
                    cap_d     = cap_q + 4'd1;
                    if (cap_q == 4'd15) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.src_ready) begin
                    if (lastBeat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        beat_d  = beat_q + BCNT_W'(1);
                        word_d  = '0;
                        cap_d   = '0;
                        oe_d    = 1'b1;
                        addr_d  = word_addr(ADDR_BASE, 32'(beat_q + BCNT_W'(1)) << 4);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.data_addr = addr_q;
    assign bus.data_oe   = oe_q;
    assign bus.src_valid = (state_q == OUT);
    assign bus.src_sop   = (state_q == OUT) && (beat_q == '0);
    assign bus.src_eop   = (state_q == OUT) && lastBeat;
    assign bus.src_dout  = beatBuf_q;

endmodule
